// File: rtl/color_input_conditioner_pkg.sv
// Shared definitions for the colour-button input conditioner: press FSM states,
// the colour codes the game FSM decodes, and small decode helpers.
package color_input_conditioner_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } press_state_e;

  localparam logic [1:0] CODE_RED   = 2'd0;
  localparam logic [1:0] CODE_GREEN = 2'd1;
  localparam logic [1:0] CODE_BLUE  = 2'd2;
  localparam logic [1:0] CODE_NONE  = 2'd3;

  function automatic logic [1:0] count_set(input logic [2:0] lvl);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < 3; i++) begin
      n = n + {1'b0, lvl[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [1:0] code_of(input logic [2:0] lvl);
    logic [1:0] c;
    c = CODE_NONE;
    if (lvl[0]) c = CODE_RED;
    else if (lvl[1]) c = CODE_GREEN;
    else if (lvl[2]) c = CODE_BLUE;
    return c;
  endfunction

endpackage

// File: rtl/color_input_conditioner_debounce_bit.sv
// One button channel: optional inversion, two-flop synchroniser, stability counter.
// COLOR_ACTIVE_LOW_EN selects pull-up (pressed = 0) buttons.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            raw_in;
  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;

`ifdef COLOR_ACTIVE_LOW_EN
  // Inverting ahead of the synchroniser lets its reset value mean "released".
  assign raw_in = ~raw;
`else
  assign raw_in = raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/color_input_conditioner.sv
// Conditions three raw colour buttons and emits one buffered press event per clean
// single-button press. Optional macro COLOR_ACTIVE_LOW_EN (see debounce_bit).
module color_input_conditioner
  import color_input_conditioner_pkg::*;
#(
  parameter int unsigned N_IN            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] color_raw,
  output logic [N_IN-1:0] color_lvl,
  output logic            press_valid,
  output logic [1:0]      press_code,
  input  logic            press_ready,
  output logic            multi_err,
  output logic            overrun
);

  press_state_e state_q, state_d;
  logic         enq;
  logic [1:0]   enq_code;
  logic         multi_d;
  logic         valid_q, multi_q, overrun_q;
  logic [1:0]   code_q;
  logic [1:0]   n_set;

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (color_raw[i]),
      .level(color_lvl[i])
    );
  end

  assign n_set = count_set(color_lvl);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (color_lvl != '0) state_d = S_HELD;
      S_HELD:  if (color_lvl == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Only the S_IDLE -> S_HELD transition can produce an event or an error.
  always_comb begin
    enq      = 1'b0;
    enq_code = CODE_NONE;
    multi_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (n_set == 2'd1) begin
        enq      = 1'b1;
        enq_code = code_of(color_lvl);
      end else if (n_set >= 2'd2) begin
        multi_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      code_q    <= CODE_NONE;
      multi_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      multi_q <= multi_d;
      if (enq && (!valid_q || press_ready)) begin
        valid_q <= 1'b1;
        code_q  <= enq_code;
      end else if (valid_q && press_ready) begin
        valid_q <= 1'b0;
        code_q  <= CODE_NONE;
      end
      if (enq && valid_q && !press_ready) overrun_q <= 1'b1;
    end
  end

  assign press_valid = valid_q;
  assign press_code  = code_q;
  assign multi_err   = multi_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_color_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// sample-window reference model of the conditioner (DEBOUNCE_CYCLES = 4).
module tb_color_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] color_raw = 3'b000;
  logic       press_ready = 1'b0;
  logic [2:0] color_lvl;
  logic       press_valid;
  logic [1:0] press_code;
  logic       multi_err;
  logic       overrun;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [2:0] hist [0:D];
  logic [2:0] m_lvl = 3'b000;
  logic       m_idle = 1'b1;
  logic       m_valid = 1'b0;
  logic [1:0] m_code = 2'd3;
  logic       m_multi = 1'b0;
  logic       m_over = 1'b0;

  color_input_conditioner #(
    .N_IN(3),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .color_raw  (color_raw),
    .color_lvl  (color_lvl),
    .press_valid(press_valid),
    .press_code (press_code),
    .press_ready(press_ready),
    .multi_err  (multi_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // hist[j] is the raw sample taken j+1 edges ago; a level flips when the D samples
  // that have made it through the synchroniser all disagree with it.
  task automatic model_step();
    logic [2:0] old;
    int         pop;
    logic       enq, take, all_diff;
    logic [1:0] c;
    old = m_lvl;
    if (reset) begin
      m_lvl = 3'b000; m_idle = 1'b1; m_valid = 1'b0; m_code = 2'd3;
      m_multi = 1'b0; m_over = 1'b0;
      for (int j = 0; j <= D; j++) hist[j] = 3'b000;
    end else begin
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++) if (hist[j][b] == old[b]) all_diff = 1'b0;
        if (all_diff) m_lvl[b] = ~old[b];
      end
      pop = $countones(old);
      c = 2'd3;
      for (int b = 0; b < 3; b++) if (old[b]) c = 2'(b);
      m_multi = m_idle && (pop >= 2);
      enq = m_idle && (pop == 1);
      take = m_valid && press_ready;
      if (enq) begin
        if (!m_valid || take) begin m_valid = 1'b1; m_code = c; end
        else m_over = 1'b1;
      end else if (take) begin
        m_valid = 1'b0; m_code = 2'd3;
      end
      if (m_idle && pop != 0) m_idle = 1'b0;
      else if (!m_idle && pop == 0) m_idle = 1'b1;
      for (int j = D; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = color_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    color_raw = 3'b000;
    press_ready = 1'b0;
    ticks(2);
    n_total++; if (color_lvl !== 3'b000) $display("FAIL reset_lvl: got %b want 000", color_lvl); else n_pass++;
    n_total++; if (press_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", press_valid); else n_pass++;
    n_total++; if (press_code !== 2'd3) $display("FAIL reset_code: got %0d want 3", press_code); else n_pass++;
    n_total++; if (multi_err !== 1'b0) $display("FAIL reset_multi: got %b want 0", multi_err); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    reset = 1'b0;
    ticks(3);
  endtask

  task automatic test_single_press();
    press_ready = 1'b1;
    color_raw = 3'b010;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_total++;
      if (press_valid !== (e == 7)) $display("FAIL single_valid e=%0d: got %b want %b", e, press_valid, (e == 7));
      else n_pass++;
      if (e == 5 || e == 6) begin
        n_total++;
        if (color_lvl !== ((e == 6) ? 3'b010 : 3'b000))
          $display("FAIL single_lvl e=%0d: got %b", e, color_lvl);
        else n_pass++;
      end
      if (e == 7) begin
        n_total++; if (press_code !== 2'd1) $display("FAIL single_code: got %0d want 1", press_code); else n_pass++;
      end
    end
    color_raw = 3'b000;
    ticks(10);
  endtask

  task automatic test_glitch();
    press_ready = 1'b1;
    color_raw = 3'b100;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 3) color_raw = 3'b000;
      n_total++;
      if (color_lvl !== 3'b000 || press_valid !== 1'b0)
        $display("FAIL glitch e=%0d: got lvl %b valid %b want 000 0", e, color_lvl, press_valid);
      else n_pass++;
    end
  endtask

  task automatic test_multi_press();
    logic seen;
    logic [1:0] code;
    press_ready = 1'b1;
    color_raw = 3'b011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_total++;
      if (multi_err !== (e == 7) || press_valid !== 1'b0)
        $display("FAIL multi e=%0d: got multi %b valid %b want %b 0", e, multi_err, press_valid, (e == 7));
      else n_pass++;
    end
    color_raw = 3'b000;
    ticks(10);
    color_raw = 3'b001;
    seen = 1'b0;
    code = 2'd3;
    for (int e = 1; e <= 20 && !seen; e++) begin
      tick();
      if (press_valid) begin seen = 1'b1; code = press_code; end
    end
    n_total++; if (seen !== 1'b1) $display("FAIL multi_after_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (code !== 2'd0) $display("FAIL multi_after_code: got %0d want 0", code); else n_pass++;
    color_raw = 3'b000;
    ticks(10);
  endtask

  task automatic test_overrun();
    press_ready = 1'b0;
    color_raw = 3'b001;
    ticks(8);
    color_raw = 3'b000;
    ticks(9);
    n_total++; if (overrun !== 1'b0) $display("FAIL ovr_before: got %b want 0", overrun); else n_pass++;
    color_raw = 3'b100;
    ticks(10);
    n_total++; if (press_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", press_valid); else n_pass++;
    n_total++; if (press_code !== 2'd0) $display("FAIL ovr_code: got %0d want 0", press_code); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else n_pass++;
    color_raw = 3'b000;
    press_ready = 1'b1;
    tick();
    n_total++; if (press_valid !== 1'b0) $display("FAIL ovr_drain_valid: got %b want 0", press_valid); else n_pass++;
    n_total++; if (press_code !== 2'd3) $display("FAIL ovr_drain_code: got %0d want 3", press_code); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
    ticks(10);
  endtask

  task automatic test_enqueue_on_drain();
    do_reset();
    press_ready = 1'b0;
    color_raw = 3'b001;
    ticks(8);
    color_raw = 3'b000;
    ticks(9);
    n_total++;
    if (press_valid !== 1'b1 || press_code !== 2'd0)
      $display("FAIL drain_pending: got valid %b code %0d want 1 0", press_valid, press_code);
    else n_pass++;
    color_raw = 3'b010;
    ticks(6);
    press_ready = 1'b1;
    tick();
    n_total++; if (press_valid !== 1'b1) $display("FAIL drain_valid: got %b want 1", press_valid); else n_pass++;
    n_total++; if (press_code !== 2'd1) $display("FAIL drain_code: got %0d want 1", press_code); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL drain_overrun: got %b want 0", overrun); else n_pass++;
    tick();
    n_total++; if (press_valid !== 1'b0) $display("FAIL drain_after: got %b want 0", press_valid); else n_pass++;
    color_raw = 3'b000;
    ticks(10);
  endtask

  task automatic test_reset_mid();
    press_ready = 1'b0;
    color_raw = 3'b001;
    ticks(2);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    n_total++;
    if (color_lvl !== 3'b000 || press_valid !== 1'b0 || press_code !== 2'd3 ||
        multi_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL midreset_outputs: got lvl %b valid %b code %0d multi %b ovr %b want 000 0 3 0 0",
               color_lvl, press_valid, press_code, multi_err, overrun);
    else n_pass++;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_total++;
      if (press_valid !== (e >= 7)) $display("FAIL midreset_valid e=%0d: got %b want %b", e, press_valid, (e >= 7));
      else n_pass++;
    end
    n_total++; if (press_code !== 2'd0) $display("FAIL midreset_code: got %0d want 0", press_code); else n_pass++;
    color_raw = 3'b000;
    press_ready = 1'b1;
    ticks(10);
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    color_raw = 3'b000;
          2:       color_raw = 3'(1 << $urandom_range(0, 2));
          3:       color_raw = 3'($urandom_range(0, 7));
          default: color_raw = color_raw ^ 3'(1 << $urandom_range(0, 2));
        endcase
        hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 14);
      end
      hold--;
      press_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++; if (color_lvl !== m_lvl) $display("FAIL rnd_lvl c=%0d: got %b want %b", cyc, color_lvl, m_lvl); else n_pass++;
      n_total++; if (press_valid !== m_valid) $display("FAIL rnd_valid c=%0d: got %b want %b", cyc, press_valid, m_valid); else n_pass++;
      n_total++; if (press_code !== m_code) $display("FAIL rnd_code c=%0d: got %0d want %0d", cyc, press_code, m_code); else n_pass++;
      n_total++; if (multi_err !== m_multi) $display("FAIL rnd_multi c=%0d: got %b want %b", cyc, multi_err, m_multi); else n_pass++;
      n_total++; if (overrun !== m_over) $display("FAIL rnd_overrun c=%0d: got %b want %b", cyc, overrun, m_over); else n_pass++;
    end
  endtask

  initial begin
    for (int j = 0; j <= D; j++) hist[j] = 3'b000;
    #1;
    test_reset();
    test_single_press();
    test_glitch();
    test_multi_press();
    test_overrun();
    test_enqueue_on_drain();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
